// File: rtl/clic_irq_arbiter_pkg.sv
// rtl/clic_irq_arbiter_pkg.sv - shared types and priority compare for the CLIC interrupt arbiter
package clic_irq_arbiter_pkg;

    localparam int unsigned CandLevelW = 16;
    localparam int unsigned CandIdW    = 16;
    localparam logic [1:0]  PrivReserved = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        HOLDOFF
    } clic_arb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            priv;
        logic [CandLevelW-1:0] level;
        logic [CandIdW-1:0]    id;
    } clic_irq_cand_t;

    // True when a should be offered ahead of b. Reserved priv never reaches
    // here as valid, so a plain numeric compare orders M > S > U.
    function automatic logic cand_wins(input clic_irq_cand_t a, input clic_irq_cand_t b);
        if (a.valid != b.valid) return a.valid;
        if (a.priv != b.priv)   return a.priv > b.priv;
        if (a.level != b.level) return a.level > b.level;
        return a.id >= b.id;
    endfunction

endpackage

// File: rtl/clic_irq_max_tree.sv
// rtl/clic_irq_max_tree.sv - binary max-reduction over interrupt candidates
// CLIC_ARB_PIPE_EN registers the tree at its midpoint level.
module clic_irq_max_tree
    import clic_irq_arbiter_pkg::*;
#(
    parameter  int unsigned NumSrc = 64,
    parameter  int unsigned LevelW = 8,
    localparam int unsigned IdW    = $clog2(NumSrc)
) (
`ifdef CLIC_ARB_PIPE_EN
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumSrc-1:0]        clr_i,
`endif
    input  logic [NumSrc-1:0]        elig_i,
    input  logic [NumSrc*LevelW-1:0] level_i,
    input  logic [NumSrc*2-1:0]      priv_i,
    output logic                     best_valid_o,
    output logic [1:0]               best_priv_o,
    output logic [LevelW-1:0]        best_level_o,
    output logic [IdW-1:0]           best_id_o
);

    localparam int unsigned NumLeaf  = 1 << IdW;
    localparam int unsigned MidDepth = IdW / 2;

`ifdef CLIC_ARB_PIPE_EN
    logic [NumLeaf-1:0] clr_pad;
    assign clr_pad = NumLeaf'(clr_i);
`endif

    // Level d holds 2**d nodes; d == IdW are the leaves, d == 0 is the winner.
    for (genvar d = IdW; d >= 0; d--) begin : g_lvl
        clic_irq_cand_t cmb [1 << d];
        clic_irq_cand_t sel [1 << d];

        if (d == IdW) begin : g_leaf
            for (genvar i = 0; i < (1 << d); i++) begin : g_n
                if (i < NumSrc) begin : g_src
                    assign cmb[i] = '{valid: elig_i[i],
                                      priv:  priv_i[2*i +: 2],
                                      level: CandLevelW'(level_i[i*LevelW +: LevelW]),
                                      id:    CandIdW'(i)};
                end else begin : g_pad
                    assign cmb[i] = '0;
                end
            end
        end else begin : g_red
            for (genvar i = 0; i < (1 << d); i++) begin : g_n
                assign cmb[i] = cand_wins(g_lvl[d+1].sel[2*i], g_lvl[d+1].sel[2*i+1])
                              ? g_lvl[d+1].sel[2*i] : g_lvl[d+1].sel[2*i+1];
            end
        end

`ifdef CLIC_ARB_PIPE_EN
        if (d == MidDepth) begin : g_pipe
            // A claimed source is dropped on entry so it cannot resurface from this stage.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < (1 << d); i++) sel[i] <= '0;
                end else begin
                    for (int i = 0; i < (1 << d); i++) begin
                        sel[i]       <= cmb[i];
                        sel[i].valid <= cmb[i].valid & ~clr_pad[cmb[i].id[IdW-1:0]];
                    end
                end
            end
        end else begin : g_pass
            assign sel = cmb;
        end
`else
        assign sel = cmb;
`endif
    end

    assign best_valid_o = g_lvl[0].sel[0].valid;
    assign best_priv_o  = g_lvl[0].sel[0].priv;
    assign best_level_o = g_lvl[0].sel[0].level[LevelW-1:0];
    assign best_id_o    = g_lvl[0].sel[0].id[IdW-1:0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// rtl/clic_irq_arbiter.sv - CLIC pending tracking, priority selection and offer/claim FSM
// CLIC_ARB_PIPE_EN adds a mid-tree register stage and a two-cycle hold-off.
module clic_irq_arbiter
    import clic_irq_arbiter_pkg::*;
#(
    parameter  int unsigned NumSrc = 64,
    parameter  int unsigned LevelW = 8,
    localparam int unsigned IdW    = $clog2(NumSrc)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumSrc-1:0]        irq_src_i,
    input  logic [NumSrc-1:0]        src_ie_i,
    input  logic [NumSrc-1:0]        src_edge_i,
    input  logic [NumSrc*LevelW-1:0] src_level_i,
    input  logic [NumSrc*2-1:0]      src_priv_i,
    input  logic                     clic_irq_ack_i,
    input  logic [IdW-1:0]           clic_irq_ack_id_i,
    output logic                     clic_irq_valid_o,
    output logic [IdW-1:0]           clic_irq_id_o,
    output logic [LevelW-1:0]        clic_irq_level_o,
    output logic [1:0]               clic_irq_priv_o,
    output logic [NumSrc-1:0]        pending_o
);

`ifdef CLIC_ARB_PIPE_EN
    localparam logic HoldLast = 1'b1;
`else
    localparam logic HoldLast = 1'b0;
`endif

    logic [NumSrc-1:0] pending_q, pending_d, src_prev_q, clr, elig;
    logic              ack_hit;
    logic              best_valid;
    logic [1:0]        best_priv;
    logic [LevelW-1:0] best_level;
    logic [IdW-1:0]    best_id;

    clic_arb_state_e   state_q, state_d;
    logic              hold_q, hold_d;
    logic              valid_q, valid_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [LevelW-1:0] level_q, level_d;
    logic [1:0]        priv_q, priv_d;

    // Decoding only real ids keeps an out-of-range ack from doing anything.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NumSrc; i++) begin
            clr[i] = clic_irq_ack_i && (clic_irq_ack_id_i == IdW'(i));
        end
    end
    assign ack_hit = |clr;

    assign pending_d = (src_edge_i & ((irq_src_i & ~src_prev_q) | (pending_q & ~clr)))
                     | (~src_edge_i & irq_src_i);

    always_comb begin
        elig = '0;
        for (int i = 0; i < NumSrc; i++) begin
            elig[i] = pending_q[i] & src_ie_i[i] & (src_priv_i[2*i +: 2] != PrivReserved);
        end
    end

    clic_irq_max_tree #(
        .NumSrc (NumSrc),
        .LevelW (LevelW)
    ) u_max_tree (
`ifdef CLIC_ARB_PIPE_EN
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr),
`endif
        .elig_i       (elig),
        .level_i      (src_level_i),
        .priv_i       (src_priv_i),
        .best_valid_o (best_valid),
        .best_priv_o  (best_priv),
        .best_level_o (best_level),
        .best_id_o    (best_id)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = 1'b0;
        unique case (state_q)
            IDLE:    if (best_valid) state_d = OFFER;
            OFFER: begin
                if (ack_hit)          state_d = HOLDOFF;
                else if (!best_valid) state_d = IDLE;
            end
            HOLDOFF: begin
                if (hold_q == HoldLast) state_d = best_valid ? OFFER : IDLE;
                else                    hold_d  = hold_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == OFFER);
        id_d    = valid_d ? best_id    : '0;
        level_d = valid_d ? best_level : '0;
        priv_d  = valid_d ? best_priv  : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            src_prev_q <= '0;
            state_q    <= IDLE;
            hold_q     <= 1'b0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            level_q    <= '0;
            priv_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            src_prev_q <= irq_src_i;
            state_q    <= state_d;
            hold_q     <= hold_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            level_q    <= level_d;
            priv_q     <= priv_d;
        end
    end

    assign clic_irq_valid_o = valid_q;
    assign clic_irq_id_o    = id_q;
    assign clic_irq_level_o = level_q;
    assign clic_irq_priv_o  = priv_q;
    assign pending_o        = pending_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb/tb_clic_irq_arbiter.sv - directed and randomized checks of clic_irq_arbiter against a reference model
module tb_clic_irq_arbiter;

    localparam int NumSrc = 64;
    localparam int LevelW = 8;
    localparam int IdW    = 6;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NumSrc-1:0]        irq_src, src_ie, src_edge;
    logic [NumSrc*LevelW-1:0] src_level;
    logic [NumSrc*2-1:0]      src_priv;
    logic                     ack;
    logic [IdW-1:0]           ack_id;
    logic                     valid_o;
    logic [IdW-1:0]           id_o;
    logic [LevelW-1:0]        level_o;
    logic [1:0]               priv_o;
    logic [NumSrc-1:0]        pending_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending set, last sampled lines, offer mode (0 idle, 1 offer, 2 hold-off).
    logic [NumSrc-1:0] m_pend, m_prev;
    int                m_mode;
    logic              e_valid;
    logic [IdW-1:0]    e_id;
    logic [LevelW-1:0] e_level;
    logic [1:0]        e_priv;

    clic_irq_arbiter #(.NumSrc(NumSrc), .LevelW(LevelW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .irq_src_i         (irq_src),
        .src_ie_i          (src_ie),
        .src_edge_i        (src_edge),
        .src_level_i       (src_level),
        .src_priv_i        (src_priv),
        .clic_irq_ack_i    (ack),
        .clic_irq_ack_id_i (ack_id),
        .clic_irq_valid_o  (valid_o),
        .clic_irq_id_o     (id_o),
        .clic_irq_level_o  (level_o),
        .clic_irq_priv_o   (priv_o),
        .pending_o         (pending_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mode = 0;
        e_valid = 1'b0; e_id = '0; e_level = '0; e_priv = '0;
    endtask

    // Best = largest score among enabled pending sources; score ranks priv, then level, then id.
    task automatic model_step();
        int best_i, best_s, s, rank;
        logic [1:0] p;
        best_i = -1; best_s = -1;
        for (int i = 0; i < NumSrc; i++) begin
            p    = src_priv[2*i +: 2];
            rank = (p == 2'b11) ? 2 : (p == 2'b01) ? 1 : 0;
            s    = rank * (1 << LevelW) * NumSrc + int'(src_level[i*LevelW +: LevelW]) * NumSrc + i;
            if (m_pend[i] && src_ie[i] && p != 2'b10 && s > best_s) begin
                best_s = s; best_i = i;
            end
        end
        if (m_mode == 1 && ack) m_mode = 2;
        else                    m_mode = (best_i >= 0) ? 1 : 0;
        e_valid = (m_mode == 1);
        e_id = '0; e_level = '0; e_priv = '0;
        if (e_valid) begin
            e_id    = best_i[IdW-1:0];
            e_level = src_level[best_i*LevelW +: LevelW];
            e_priv  = src_priv[2*best_i +: 2];
        end
        for (int i = 0; i < NumSrc; i++) begin
            if (!src_edge[i])                  m_pend[i] = irq_src[i];
            else if (irq_src[i] && !m_prev[i]) m_pend[i] = 1'b1;
            else if (ack && int'(ack_id) == i) m_pend[i] = 1'b0;
        end
        m_prev = irq_src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq_src = '0; src_ie = '0; src_edge = '0; src_level = '0; src_priv = '0;
        ack = 1'b0; ack_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid_o, id_o, level_o, priv_o} !== '0) begin
            failures++; $display("FAIL reset_out actual=%h required=0", {valid_o, id_o, level_o, priv_o});
        end
        checks++;
        if (pending_o !== '0) begin
            failures++; $display("FAIL reset_pend actual=%h required=0", pending_o);
        end
        repeat (2) tick();
        checks++;
        if (valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_idle actual=%b required=0", valid_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        src_edge[5] = 1'b1; src_ie[5] = 1'b1; src_level[5*LevelW +: LevelW] = 8'd3; src_priv[10 +: 2] = 2'b11;
        tick();
        irq_src[5] = 1'b1;
        tick();
        checks++;
        if ({pending_o[5], valid_o} !== 2'b10) begin
            failures++; $display("FAIL single_pend actual=%b required=10", {pending_o[5], valid_o});
        end
        irq_src[5] = 1'b0;
        tick();
        checks++;
        if ({valid_o, id_o, level_o, priv_o} !== {1'b1, 6'd5, 8'd3, 2'b11}) begin
            failures++; $display("FAIL single_offer actual=%h required=%h", {valid_o, id_o, level_o, priv_o}, {1'b1, 6'd5, 8'd3, 2'b11});
        end
        ack = 1'b1; ack_id = 6'd5;
        tick();
        ack = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            failures++; $display("FAIL single_holdoff actual=%b required=0", valid_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({valid_o, pending_o[5]} !== 2'b00 || valid_o !== e_valid) begin
                failures++; $display("FAIL single_after cyc=%0d actual=%b required=00", c, {valid_o, pending_o[5]});
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        src_edge[2] = 1'b1; src_ie[2] = 1'b1; src_priv[4 +: 2]  = 2'b01; src_level[2*LevelW +: LevelW] = 8'd200;
        src_edge[7] = 1'b1; src_ie[7] = 1'b1; src_priv[14 +: 2] = 2'b11; src_level[7*LevelW +: LevelW] = 8'd10;
        irq_src[2] = 1'b1; irq_src[7] = 1'b1;
        tick();
        irq_src = '0;
        tick();
        checks++;
        if ({valid_o, id_o} !== {1'b1, 6'd7} || id_o !== e_id) begin
            failures++; $display("FAIL prio_priv actual=%b/%0d required=1/7", valid_o, id_o);
        end
        ack = 1'b1; ack_id = 6'd7;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if ({valid_o, id_o, level_o, priv_o} !== {1'b1, 6'd2, 8'd200, 2'b01}) begin
            failures++; $display("FAIL prio_next actual=%h required=%h", {valid_o, id_o, level_o, priv_o}, {1'b1, 6'd2, 8'd200, 2'b01});
        end
        ack = 1'b1; ack_id = 6'd2;
        tick();
        ack = 1'b0;
        src_edge[3] = 1'b1; src_ie[3] = 1'b1; src_priv[6 +: 2]  = 2'b11; src_level[3*LevelW +: LevelW] = 8'd50;
        src_edge[9] = 1'b1; src_ie[9] = 1'b1; src_priv[18 +: 2] = 2'b11; src_level[9*LevelW +: LevelW] = 8'd50;
        irq_src[3] = 1'b1; irq_src[9] = 1'b1;
        tick();
        irq_src = '0;
        tick();
        checks++;
        if ({valid_o, id_o, level_o} !== {1'b1, 6'd9, 8'd50}) begin
            failures++; $display("FAIL prio_tie actual=%b/%0d/%0d required=1/9/50", valid_o, id_o, level_o);
        end
    endtask

    task automatic test_level();
        do_reset();
        src_ie[4] = 1'b1; src_priv[8 +: 2] = 2'b11; src_level[4*LevelW +: LevelW] = 8'd5;
        irq_src[4] = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_o, id_o} !== {1'b1, 6'd4}) begin
            failures++; $display("FAIL level_offer actual=%b/%0d required=1/4", valid_o, id_o);
        end
        ack = 1'b1; ack_id = 6'd4;
        tick();
        ack = 1'b0;
        checks++;
        if ({valid_o, pending_o[4]} !== 2'b01) begin
            failures++; $display("FAIL level_holdoff actual=%b required=01", {valid_o, pending_o[4]});
        end
        tick();
        checks++;
        if ({valid_o, id_o} !== {1'b1, 6'd4}) begin
            failures++; $display("FAIL level_reoffer actual=%b/%0d required=1/4", valid_o, id_o);
        end
        irq_src[4] = 1'b0;
        tick();
        checks++;
        if (valid_o !== e_valid) begin
            failures++; $display("FAIL level_drop1 actual=%b required=%b", valid_o, e_valid);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            failures++; $display("FAIL level_drop2 actual=%b required=0", valid_o);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        src_edge[1] = 1'b1; src_ie[1] = 1'b1; src_priv[2 +: 2]  = 2'b11; src_level[1*LevelW +: LevelW] = 8'd20;
        src_edge[6] = 1'b1; src_ie[6] = 1'b1; src_priv[12 +: 2] = 2'b11; src_level[6*LevelW +: LevelW] = 8'd90;
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        tick();
        irq_src[6] = 1'b1;
        tick();
        checks++;
        if ({valid_o, id_o} !== {1'b1, 6'd1}) begin
            failures++; $display("FAIL preempt_old actual=%b/%0d required=1/1", valid_o, id_o);
        end
        irq_src[6] = 1'b0;
        tick();
        checks++;
        if ({valid_o, id_o, level_o} !== {1'b1, 6'd6, 8'd90}) begin
            failures++; $display("FAIL preempt_new actual=%b/%0d/%0d required=1/6/90", valid_o, id_o, level_o);
        end
        ack = 1'b1; ack_id = 6'd6; irq_src[6] = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({pending_o[6], valid_o} !== 2'b10) begin
            failures++; $display("FAIL set_wins actual=%b required=10", {pending_o[6], valid_o});
        end
        irq_src[6] = 1'b0;
        tick();
        checks++;
        if ({valid_o, id_o} !== {1'b1, 6'd6}) begin
            failures++; $display("FAIL set_wins_offer actual=%b/%0d required=1/6", valid_o, id_o);
        end
    endtask

    task automatic test_mask();
        do_reset();
        src_edge[10] = 1'b1; src_priv[20 +: 2] = 2'b11; src_level[10*LevelW +: LevelW] = 8'd7;
        irq_src[10] = 1'b1;
        tick();
        irq_src[10] = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid_o, pending_o[10]} !== 2'b01) begin
            failures++; $display("FAIL mask_hold actual=%b required=01", {valid_o, pending_o[10]});
        end
        src_ie[10] = 1'b1;
        tick();
        checks++;
        if ({valid_o, id_o} !== {1'b1, 6'd10}) begin
            failures++; $display("FAIL mask_enable actual=%b/%0d required=1/10", valid_o, id_o);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid_o, id_o, level_o, priv_o, pending_o} !== '0) begin
            failures++; $display("FAIL reset_async actual=%b/%0d/%0d/%h required=0", valid_o, id_o, level_o, pending_o);
        end
        @(posedge clk);
        #1;
        irq_src = '0;
        model_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0 || pending_o !== '0) begin
                failures++; $display("FAIL reset_no_offer cyc=%0d actual=%b/%h required=0/0", c, valid_o, pending_o);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            src_edge = {$urandom, $urandom};
            src_ie   = {$urandom, $urandom} | {$urandom, $urandom};
            for (int i = 0; i < NumSrc; i++) begin
                src_level[i*LevelW +: LevelW] = 8'($urandom_range(0, 3));
                src_priv[2*i +: 2]            = 2'($urandom);
            end
            for (int c = 0; c < 300; c++) begin
                irq_src ^= {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                if ($urandom_range(0, 15) == 0) src_ie ^= 64'(1) << $urandom_range(0, NumSrc - 1);
                ack    = ($urandom_range(0, 2) == 0);
                ack_id = ($urandom_range(0, 1) == 0) ? e_id : 6'($urandom);
                tick();
                checks++;
                if ({valid_o, id_o, level_o, priv_o} !== {e_valid, e_id, e_level, e_priv}) begin
                    failures++;
                    $display("FAIL rand_out blk=%0d cyc=%0d actual=%b/%0d/%0d/%0d required=%b/%0d/%0d/%0d",
                             blk, c, valid_o, id_o, level_o, priv_o, e_valid, e_id, e_level, e_priv);
                end
                checks++;
                if (pending_o !== m_pend) begin
                    failures++; $display("FAIL rand_pend blk=%0d cyc=%0d actual=%h required=%h", blk, c, pending_o, m_pend);
                end
            end
        end
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_level();
        test_preempt();
        test_mask();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
